approx_adder_error_monitor: RTL and testbench

- Sequential reader/checker for the outputs of a combinational approximate adder.
- On `start`, it sweeps every operand pair on the adder's inputs, one vector per cycle, and reads back the approximate sum.
- For each vector it compares the approximate sum against the exact sum and accumulates error metrics: worst-case error, mismatch count, threshold-violation count and summed absolute error.
- It sits beside the approximate adder in the evaluation harness. It reports a pass/fail verdict against the error threshold ET the adder was synthesised for.

---
 rtl/approx_adder_error_monitor_if.sv | 31 +++
 rtl/approx_adder_error_monitor.sv | 126 ++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/approx_adder_error_monitor_if.sv
// Bus between the error monitor and its harness: adder operands,
// the approximate sum read back, and the accumulated error metrics.
interface approx_adder_error_monitor_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3
);
    logic                      start;
    logic [IN_W-1:0]           dut_a;
    logic [IN_W-1:0]           dut_b;
    logic [OUT_W-1:0]          dut_sum;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [OUT_W-1:0]          max_err;
    logic [2*IN_W-1:0]         wce_vec;
    logic [2*IN_W:0]           mismatch_cnt;
    logic [2*IN_W:0]           viol_cnt;
    logic [OUT_W+2*IN_W-1:0]   sum_abs_err;

    modport slave (
        input  start, dut_sum,
        output dut_a, dut_b, busy, done, pass, max_err,
               wce_vec, mismatch_cnt, viol_cnt, sum_abs_err
    );

    modport master (
        output start, dut_sum,
        input  dut_a, dut_b, busy, done, pass, max_err,
               wce_vec, mismatch_cnt, viol_cnt, sum_abs_err
    );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Exhaustive sweep of an approximate adder's operand space, one vector
// per cycle, accumulating error metrics and a pass/fail verdict vs ET.
module approx_adder_error_monitor #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3,
    parameter int ET    = 0
) (
    input  logic clk,
    input  logic rst_n,
    approx_adder_error_monitor_if.slave bus
);
    localparam int VW = 2 * IN_W;
    localparam int CW = 2 * IN_W + 1;
    localparam int SW = OUT_W + 2 * IN_W;
    localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [OUT_W-1:0]  max_q, max_d;
    logic [VW-1:0]     wce_q, wce_d;
    logic [CW-1:0]     mis_q, mis_d;
    logic [CW-1:0]     viol_q, viol_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic              pass_q, pass_d;

    logic              go;
    logic              last;
    logic [OUT_W-1:0]  exact;
    logic signed [OUT_W:0] diff;
    logic [OUT_W:0]    mag;
    logic [OUT_W-1:0]  abs_err;

    assign go    = bus.start && (state_q != RUN);
    assign last  = (vec_q == {VW{1'b1}});
    assign exact = OUT_W'(bus.dut_a) + OUT_W'(bus.dut_b);
    assign diff  = $signed({1'b0, exact}) - $signed({1'b0, bus.dut_sum});
    assign mag   = diff[OUT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign abs_err = mag[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
    end

    always_comb begin
        vec_d  = vec_q;
        max_d  = max_q;
        wce_d  = wce_q;
        mis_d  = mis_q;
        viol_d = viol_q;
        sum_d  = sum_q;
        pass_d = pass_q;
        if (go) begin
            vec_d  = '0;
            max_d  = '0;
            wce_d  = '0;
            mis_d  = '0;
            viol_d = '0;
            sum_d  = '0;
            pass_d = 1'b0;
        end else if (state_q == RUN) begin
            // strict compare keeps the first vector reaching the max
            if (abs_err > max_q) begin
                max_d = abs_err;
                wce_d = vec_q;
            end
            mis_d  = mis_q + CW'(abs_err != '0);
            viol_d = viol_q + CW'(abs_err > ET_V);
            sum_d  = sum_q + SW'(abs_err);
            if (last) begin
                pass_d = (max_d <= ET_V);
            end else begin
                vec_d = vec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            max_q  <= '0;
            wce_q  <= '0;
            mis_q  <= '0;
            viol_q <= '0;
            sum_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            max_q  <= max_d;
            wce_q  <= wce_d;
            mis_q  <= mis_d;
            viol_q <= viol_d;
            sum_q  <= sum_d;
            pass_q <= pass_d;
        end
    end

    assign bus.dut_a        = vec_q[IN_W-1:0];
    assign bus.dut_b        = vec_q[VW-1:IN_W];
    assign bus.pass         = pass_q;
    assign bus.max_err      = max_q;
    assign bus.wce_vec      = wce_q;
    assign bus.mismatch_cnt = mis_q;
    assign bus.viol_cnt     = viol_q;
    assign bus.sum_abs_err  = sum_q;
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench: three monitors (ET=0,2,1) beside modelled adders,
// expected metrics queued at start and compared at done.
module tb_approx_adder_error_monitor;
    typedef struct {
        logic [31:0] mx;
        logic [31:0] wce;
        logic [31:0] mis;
        logic [31:0] viol;
        logic [31:0] sum;
        logic [31:0] pass;
        logic [31:0] ab;
    } exp_t;

    logic clk;
    logic rst_n;
    logic st [3];
    int   m0;
    int   total;
    int   bad;
    exp_t sb [$];

    approx_adder_error_monitor_if #(.IN_W(2), .OUT_W(3)) b0 ();
    approx_adder_error_monitor_if #(.IN_W(2), .OUT_W(3)) b1 ();
    approx_adder_error_monitor_if #(.IN_W(2), .OUT_W(3)) b2 ();

    approx_adder_error_monitor #(.IN_W(2), .OUT_W(3), .ET(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    approx_adder_error_monitor #(.IN_W(2), .OUT_W(3), .ET(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    approx_adder_error_monitor #(.IN_W(2), .OUT_W(3), .ET(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    // mode 0: exact, 1: tied to zero, 2: exact with LSB forced 0
    function automatic logic [2:0] adder(int mode, logic [1:0] a, logic [1:0] b);
        logic [2:0] ex;
        ex = {1'b0, a} + {1'b0, b};
        case (mode)
            0:       return ex;
            1:       return 3'd0;
            default: return {ex[2:1], 1'b0};
        endcase
    endfunction

    assign b0.start = st[0];
    assign b1.start = st[1];
    assign b2.start = st[2];
    assign b0.dut_sum = adder(m0, b0.dut_a, b0.dut_b);
    assign b1.dut_sum = adder(1, b1.dut_a, b1.dut_b);
    assign b2.dut_sum = adder(2, b2.dut_a, b2.dut_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_exp(int mode, int et);
        exp_t e;
        int mx, w, mis, viol, sum, ex, s, err;
        mx = 0; w = 0; mis = 0; viol = 0; sum = 0;
        for (int v = 0; v < 16; v++) begin
            ex  = (v % 4) + (v / 4);
            s   = int'(adder(mode, 2'(v % 4), 2'(v / 4)));
            err = (ex > s) ? ex - s : s - ex;
            if (err > mx) begin
                mx = err;
                w  = v;
            end
            mis  += (err != 0) ? 1 : 0;
            viol += (err > et) ? 1 : 0;
            sum  += err;
        end
        e.mx = mx; e.wce = w; e.mis = mis; e.viol = viol;
        e.sum = sum; e.pass = (mx <= et) ? 1 : 0; e.ab = 15;
        return e;
    endfunction

    function automatic exp_t obs_of(int inst);
        exp_t o;
        case (inst)
            0: begin
                o.mx = 32'(b0.max_err); o.wce = 32'(b0.wce_vec);
                o.mis = 32'(b0.mismatch_cnt); o.viol = 32'(b0.viol_cnt);
                o.sum = 32'(b0.sum_abs_err); o.pass = 32'(b0.pass);
                o.ab = 32'({b0.dut_b, b0.dut_a});
            end
            1: begin
                o.mx = 32'(b1.max_err); o.wce = 32'(b1.wce_vec);
                o.mis = 32'(b1.mismatch_cnt); o.viol = 32'(b1.viol_cnt);
                o.sum = 32'(b1.sum_abs_err); o.pass = 32'(b1.pass);
                o.ab = 32'({b1.dut_b, b1.dut_a});
            end
            default: begin
                o.mx = 32'(b2.max_err); o.wce = 32'(b2.wce_vec);
                o.mis = 32'(b2.mismatch_cnt); o.viol = 32'(b2.viol_cnt);
                o.sum = 32'(b2.sum_abs_err); o.pass = 32'(b2.pass);
                o.ab = 32'({b2.dut_b, b2.dut_a});
            end
        endcase
        return o;
    endfunction

    function automatic logic [1:0] bd_of(int inst);
        case (inst)
            0:       return {b0.busy, b0.done};
            1:       return {b1.busy, b1.done};
            default: return {b2.busy, b2.done};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic chk_zero(int inst, string tag);
        exp_t o;
        o = obs_of(inst);
        chk({tag, "_busydone"}, 32'(bd_of(inst)), 0);
        chk({tag, "_pass"}, o.pass, 0);
        chk({tag, "_max"}, o.mx, 0);
        chk({tag, "_wce"}, o.wce, 0);
        chk({tag, "_mis"}, o.mis, 0);
        chk({tag, "_viol"}, o.viol, 0);
        chk({tag, "_sum"}, o.sum, 0);
        chk({tag, "_vec"}, o.ab, 0);
    endtask

    task automatic run_sweep(string tag, int inst, int mode, int et, int poke);
        exp_t e;
        exp_t o;
        int   cyc;
        sb.push_back(model_exp(mode, et));
        @(negedge clk);
        if (inst == 0) m0 = mode;
        st[inst] = 1'b1;
        @(negedge clk);
        st[inst] = 1'b0;
        o = obs_of(inst);
        chk({tag, "_c0_busydone"}, 32'(bd_of(inst)), 2);
        chk({tag, "_c0_max"}, o.mx, 0);
        chk({tag, "_c0_mis"}, o.mis, 0);
        chk({tag, "_c0_sum"}, o.sum, 0);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) st[inst] = 1'b1;
            if (cyc == poke + 1) st[inst] = 1'b0;
            if (bd_of(inst)[0] === 1'b1) break;
            if (cyc >= 40) break;
        end
        chk({tag, "_done_cycle"}, cyc, 16);
        chk({tag, "_busydone"}, 32'(bd_of(inst)), 1);
        e = sb.pop_front();
        o = obs_of(inst);
        chk({tag, "_max"}, o.mx, e.mx);
        chk({tag, "_wce"}, o.wce, e.wce);
        chk({tag, "_mis"}, o.mis, e.mis);
        chk({tag, "_viol"}, o.viol, e.viol);
        chk({tag, "_sum"}, o.sum, e.sum);
        chk({tag, "_pass"}, o.pass, e.pass);
        chk({tag, "_vec_hold"}, o.ab, e.ab);
    endtask

    initial begin
        total = 0;
        bad = 0;
        m0 = 0;
        st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        rst_n = 1'b1;

        run_sweep("exact_et0", 0, 0, 0, -1);
        run_sweep("zero_et0", 0, 1, 0, -1);
        run_sweep("zero_et2", 1, 1, 2, -1);
        run_sweep("lsb_et1", 2, 2, 1, -1);
        run_sweep("poke_run", 0, 1, 0, 5);
        run_sweep("restart_done", 1, 1, 2, -1);

        @(negedge clk);
        m0 = 1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_vec", 32'({b0.dut_b, b0.dut_a}), 7);
        chk("pre_rst_mis", 32'(b0.mismatch_cnt), 6);
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "async_rst");
        @(negedge clk);
        chk_zero(0, "rst_hold");
        rst_n = 1'b1;
        run_sweep("after_rst", 0, 1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
